release_sink_unit: RTL and testbench
====================================

Name: release_sink_unit

Overview:
- Manager-side terminator of TileLink-C channel C for the L1 data cache writeback path.
- Accepts ProbeAck, ProbeAckData, Release and ReleaseData bursts from the cache writeback unit and captures full-block data into a local buffer.
- Drains the buffer beat-by-beat to the backing-store write port.
- Answers voluntary releases with ReleaseAck on channel D, and reports probe completions to the probe issuer.

Parameters:
- DATA_W, 64, channel C beat width and backing-store row width (bits).
- BEATS, 8, beats per cache block (refill cycles); power of two, at least 1.
- ADDR_W, 32, physical address width.
- SRC_W, 3, TileLink source id width.
- BLOCK_OFF, 6, log2 of block bytes.

Ports:
- clock  in  1  Rising-edge clock.
- reset  in  1  Reset; synchronous, active-high.
- c_valid  in  1  Channel C beat valid.
- c_ready  out  1  Channel C beat ready.
- c_opcode  in  3  4=ProbeAck, 5=ProbeAckData, 6=Release, 7=ReleaseData.
- c_param  in  3  Shrink/report permission.
- c_size  in  4  log2 transfer bytes.
- c_source  in  SRC_W  Requester id.
- c_address  in  ADDR_W  Block address.
- c_data  in  DATA_W  Beat data.
- wr_valid  out  1  Backing-store write valid.
- wr_ready  in  1  Backing-store write ready.
- wr_addr  out  ADDR_W  Row byte address.
- wr_data  out  DATA_W  Row data.
- d_valid  out  1  ReleaseAck valid.
- d_ready  in  1  ReleaseAck ready.
- d_opcode  out  3  Constant 6 (ReleaseAck) while d_valid.
- d_source  out  SRC_W  Latched source.
- d_size  out  4  Latched size.
- probe_done  out  1  One-cycle pulse when a probe response is fully absorbed.
- probe_param  out  3  Latched param, valid with probe_done.
- busy  out  1  High in every state except s_idle.
- busy_addr  out  ADDR_W  Latched block address; used by the cache for set-conflict blocking.
- proto_err  out  1  Sticky protocol-error flag.

Behaviour:
- Reset (synchronous, active-high):
  - state=s_idle; beat counter=0; all latched fields=0; proto_err=0.
  - All valid outputs and probe_done are low.
  - Buffer contents are don't-care.
  - Reset in any state aborts the transaction with no write or ack issued.
- Handshakes:
  - A fire is valid&&ready.
  - Outputs are driven combinationally from state and registers only; none depends on a same-cycle ready.
  - c_ready is high only in s_idle and s_fill.
- s_idle, on a C fire:
  - Latch opcode, param, size, source, and address with its low BLOCK_OFF bits cleared.
  - Opcode 5 or 7: buf[0]<=c_data, cnt<=1. Go to s_fill; if BEATS==1 go straight to s_write with cnt<=0.
  - Opcode 4: go to s_probe.
  - Opcode 6: go to s_ack.
  - Opcodes 0-3: set proto_err and stay in s_idle.
- s_fill, on each C fire:
  - buf[cnt]<=c_data.
  - If the beat's opcode or source differs from the latched value, set proto_err; the beat is still stored.
  - When cnt==BEATS-1: cnt<=0 and go to s_write. Otherwise cnt<=cnt+1.
- s_write:
  - wr_valid=1; wr_addr=block_addr + cnt*(DATA_W/8); wr_data=buf[cnt].
  - On a fire with cnt==BEATS-1: cnt<=0. Go to s_ack if the latched opcode is 7, or to s_probe if it is 5.
  - Otherwise a fire advances cnt.
  - wr_ready low stalls with all outputs held stable.
- s_ack:
  - d_valid=1, d_opcode=6, d_source and d_size from the latched values.
  - d_fire goes to s_idle; held indefinitely until d_ready.
- s_probe:
  - probe_done=1 and probe_param=latched param for exactly one cycle, then s_idle.
- Back-to-back: a new C beat is accepted on the cycle after the return to s_idle, never in the same cycle as d_fire or probe_done.
- Counter is $clog2(BEATS) bits and never wraps past BEATS-1.
- Total latency for a data burst with no stalls: BEATS accept cycles, then BEATS write cycles, then 1 ack/done cycle.

Test Plan:
- ReleaseData, src=2, addr=0x8000_0040, beats 0x11..0x88, wr_ready=1, d_ready=1 -> 8 writes at 0x8000_0040..0x8000_0078 carrying data 0x11..0x88 in order; then d_valid with opcode 6, source 2, size 6; busy falls the cycle after d_fire.
- ProbeAckData, param=1, with wr_ready toggling every other cycle -> writes stall and resume with data unchanged; probe_done pulses for exactly one cycle with probe_param=1; no d_valid ever.
- Release (no data) with d_ready held low for 5 cycles -> zero writes; d_valid stays high 5 cycles with stable fields; c_ready=0 throughout.
- Plain ProbeAck, param=2 -> probe_done pulses on the cycle after the C fire; busy high for exactly 1 cycle.
- ReleaseData with beat 3 carrying source 5 instead of 2 -> proto_err set and stays set; all 8 beats are still written.
- Reset asserted mid-s_write after 3 writes -> next cycle: busy=0, wr_valid=0, proto_err=0, c_ready=1; no ReleaseAck issued.

Source files
------------

// File: rtl/release_sink_unit.sv
// Channel C sink for L1 writebacks: absorbs ProbeAck/Release bursts,
// drains block data to the backing store, issues ReleaseAck / probe_done.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   c_*               TileLink channel C beat input (valid/ready)
//   wr_*              backing-store row write (valid/ready)
//   d_*               channel D ReleaseAck output (valid/ready)
//   probe_done/param  one-cycle probe completion report
//   busy, busy_addr   block-in-flight indication for set-conflict blocking
//   proto_err         sticky protocol-error flag
module release_sink_unit #(
   parameter int DATA_W    = 64,
   parameter int BEATS     = 8,
   parameter int ADDR_W    = 32,
   parameter int SRC_W     = 3,
   parameter int BLOCK_OFF = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              c_valid,
   output logic              c_ready,
   input  logic [2:0]        c_opcode,
   input  logic [2:0]        c_param,
   input  logic [3:0]        c_size,
   input  logic [SRC_W-1:0]  c_source,
   input  logic [ADDR_W-1:0] c_address,
   input  logic [DATA_W-1:0] c_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              d_valid,
   input  logic              d_ready,
   output logic [2:0]        d_opcode,
   output logic [SRC_W-1:0]  d_source,
   output logic [3:0]        d_size,
   output logic              probe_done,
   output logic [2:0]        probe_param,
   output logic              busy,
   output logic [ADDR_W-1:0] busy_addr,
   output logic              proto_err
);

   // One-bit counter minimum keeps BEATS==1 legal.
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
   localparam logic [ADDR_W-1:0] ROW_B = ADDR_W'(DATA_W / 8);
   localparam logic [ADDR_W-1:0] OFF_MASK =
      ADDR_W'((64'd1 << BLOCK_OFF) - 64'd1);

   localparam logic [2:0] OP_PACK  = 3'd4;
   localparam logic [2:0] OP_PACKD = 3'd5;
   localparam logic [2:0] OP_REL   = 3'd6;
   localparam logic [2:0] OP_RELD  = 3'd7;

   typedef enum logic [2:0] {
      s_idle,
      s_fill,
      s_write,
      s_ack,
      s_probe
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [2:0]        op_q;
   logic [2:0]        param_q;
   logic [3:0]        size_q;
   logic [SRC_W-1:0]  src_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] blk_buf [2**CW];

   logic c_fire;
   logic wr_fire;
   logic d_fire;

   assign c_fire  = c_valid && c_ready;
   assign wr_fire = wr_valid && wr_ready;
   assign d_fire  = d_valid && d_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= s_idle;
         cnt       <= '0;
         op_q      <= '0;
         param_q   <= '0;
         size_q    <= '0;
         src_q     <= '0;
         addr_q    <= '0;
         proto_err <= 1'b0;
      end else begin
         unique case (state)
            s_idle: begin
               if (c_fire) begin
                  op_q    <= c_opcode;
                  param_q <= c_param;
                  size_q  <= c_size;
                  src_q   <= c_source;
                  addr_q  <= c_address & ~OFF_MASK;
                  unique case (1'b1)
                     (c_opcode == OP_PACKD) || (c_opcode == OP_RELD): begin
                        if (BEATS == 1) begin
                           cnt   <= '0;
                           state <= s_write;
                        end else begin
                           cnt   <= CW'(1);
                           state <= s_fill;
                        end
                     end
                     c_opcode == OP_PACK: state <= s_probe;
                     c_opcode == OP_REL:  state <= s_ack;
                     default:             proto_err <= 1'b1;
                  endcase
               end
            end
            s_fill: begin
               if (c_fire) begin
                  // A mismatched beat is still stored so the block stays whole.
                  if (c_opcode != op_q || c_source != src_q)
                     proto_err <= 1'b1;
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= s_write;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            s_write: begin
               if (wr_fire) begin
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= (op_q == OP_RELD) ? s_ack : s_probe;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            s_ack: begin
               if (d_fire)
                  state <= s_idle;
            end
            s_probe: state <= s_idle;
            default: state <= s_idle;
         endcase
      end
   end

   // Data buffer carries no reset; contents are only read after a fill.
   always_ff @(posedge clock) begin
      if (c_fire) begin
         if (state == s_idle)
            blk_buf[0] <= c_data;
         else
            blk_buf[cnt] <= c_data;
      end
   end

   assign c_ready     = (state == s_idle) || (state == s_fill);
   assign wr_valid    = (state == s_write);
   assign wr_addr     = addr_q + ({{(ADDR_W-CW){1'b0}}, cnt} * ROW_B);
   assign wr_data     = blk_buf[cnt];
   assign d_valid     = (state == s_ack);
   assign d_opcode    = d_valid ? OP_REL : 3'd0;
   assign d_source    = src_q;
   assign d_size      = size_q;
   assign probe_done  = (state == s_probe);
   assign probe_param = param_q;
   assign busy        = (state != s_idle);
   assign busy_addr   = addr_q;

endmodule

// File: tb/tb_release_sink_unit.sv
// Directed bench for release_sink_unit: hand-computed expectations for
// ReleaseData, ProbeAckData, Release, ProbeAck, errors and reset abort.
module tb_release_sink_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        c_valid;
   logic        c_ready;
   logic [2:0]  c_opcode;
   logic [2:0]  c_param;
   logic [3:0]  c_size;
   logic [2:0]  c_source;
   logic [31:0] c_address;
   logic [63:0] c_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_addr;
   logic [63:0] wr_data;
   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_opcode;
   logic [2:0]  d_source;
   logic [3:0]  d_size;
   logic        probe_done;
   logic [2:0]  probe_param;
   logic        busy;
   logic [31:0] busy_addr;
   logic        proto_err;

   int vectors = 0;
   int miscompares = 0;

   release_sink_unit dut (
      .clock(clock), .reset(reset),
      .c_valid(c_valid), .c_ready(c_ready),
      .c_opcode(c_opcode), .c_param(c_param),
      .c_size(c_size), .c_source(c_source),
      .c_address(c_address), .c_data(c_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .d_valid(d_valid), .d_ready(d_ready),
      .d_opcode(d_opcode), .d_source(d_source),
      .d_size(d_size), .probe_done(probe_done),
      .probe_param(probe_param), .busy(busy),
      .busy_addr(busy_addr), .proto_err(proto_err)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Stimulus only: drives a full data burst, source overridable on one beat.
   task automatic send_burst(input logic [2:0] op, input logic [2:0] p,
                             input logic [2:0] src, input logic [31:0] a,
                             input logic [63:0] dbase, input int bad_beat,
                             input logic [2:0] bad_src);
      for (int i = 0; i < 8; i++) begin
         c_valid   = 1'b1;
         c_opcode  = op;
         c_param   = p;
         c_size    = 4'd6;
         c_source  = (i == bad_beat) ? bad_src : src;
         c_address = a;
         c_data    = dbase * 64'(i + 1);
         tick();
      end
      c_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; c_valid = 1'b0; wr_ready = 1'b0; d_ready = 1'b0;
      c_opcode = 3'd0; c_param = 3'd0; c_size = 4'd0; c_source = 3'd0;
      c_address = 32'd0; c_data = 64'd0;
      tick(); tick();
      reset = 1'b0;
      vectors++;
      if (busy !== 1'b0 || c_ready !== 1'b1 || wr_valid !== 1'b0 ||
          d_valid !== 1'b0 || probe_done !== 1'b0 || proto_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctl got busy=%b crdy=%b wv=%b dv=%b pd=%b pe=%b want 0 1 0 0 0 0",
                  busy, c_ready, wr_valid, d_valid, probe_done, proto_err);
      end
      vectors++;
      if (busy_addr !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_addr got %h want 0", busy_addr);
      end
   endtask

   task automatic test_release_data();
      wr_ready = 1'b1; d_ready = 1'b1;
      send_burst(3'd7, 3'd0, 3'd2, 32'h8000_0040, 64'h11, -1, 3'd0);
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (wr_valid !== 1'b1 || wr_addr !== 32'h8000_0040 + 32'(8 * i) ||
             wr_data !== 64'h11 * 64'(i + 1)) begin
            miscompares++;
            $display("FAIL rd_write%0d got v=%b a=%h d=%h want 1 %h %h", i,
                     wr_valid, wr_addr, wr_data, 32'h8000_0040 + 32'(8 * i),
                     64'h11 * 64'(i + 1));
         end
         tick();
      end
      vectors++;
      if (d_valid !== 1'b1 || d_opcode !== 3'd6 || d_source !== 3'd2 ||
          d_size !== 4'd6 || wr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rd_ack got v=%b op=%0d src=%0d sz=%0d wv=%b want 1 6 2 6 0",
                  d_valid, d_opcode, d_source, d_size, wr_valid);
      end
      vectors++;
      if (busy_addr !== 32'h8000_0040 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rd_busy got busy=%b addr=%h want 1 80000040", busy, busy_addr);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || d_valid !== 1'b0 || c_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rd_done got busy=%b dv=%b crdy=%b want 0 0 1",
                  busy, d_valid, c_ready);
      end
   endtask

   task automatic test_probe_data();
      int idx = 0;
      int pulses = 0;
      int dv_seen = 0;
      d_ready = 1'b1;
      send_burst(3'd5, 3'd1, 3'd1, 32'h0000_1000, 64'h0101, -1, 3'd0);
      for (int cyc = 0; cyc < 60; cyc++) begin
         wr_ready = cyc[0];
         if (wr_valid) begin
            vectors++;
            if (wr_addr !== 32'h1000 + 32'(8 * idx) ||
                wr_data !== 64'h0101 * 64'(idx + 1)) begin
               miscompares++;
               $display("FAIL pd_write%0d got a=%h d=%h want %h %h", idx,
                        wr_addr, wr_data, 32'h1000 + 32'(8 * idx),
                        64'h0101 * 64'(idx + 1));
            end
            if (wr_ready) idx++;
         end
         if (probe_done) begin
            pulses++;
            vectors++;
            if (probe_param !== 3'd1) begin
               miscompares++;
               $display("FAIL pd_param got %0d want 1", probe_param);
            end
         end
         if (d_valid) dv_seen++;
         if (!busy) break;
         tick();
      end
      vectors++;
      if (idx !== 8 || pulses !== 1 || dv_seen !== 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL pd_summary got writes=%0d pulses=%0d dvalid=%0d busy=%b want 8 1 0 0",
                  idx, pulses, dv_seen, busy);
      end
      wr_ready = 1'b1;
   endtask

   task automatic test_release_wait();
      d_ready = 1'b0;
      c_valid = 1'b1; c_opcode = 3'd6; c_param = 3'd3; c_size = 4'd6;
      c_source = 3'd3; c_address = 32'h0000_2043; c_data = 64'd0;
      tick();
      c_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (d_valid !== 1'b1 || d_opcode !== 3'd6 || d_source !== 3'd3 ||
             d_size !== 4'd6 || c_ready !== 1'b0 || wr_valid !== 1'b0 ||
             busy_addr !== 32'h0000_2040) begin
            miscompares++;
            $display("FAIL rel_hold%0d got dv=%b op=%0d src=%0d sz=%0d crdy=%b wv=%b a=%h want 1 6 3 6 0 0 00002040",
                     i, d_valid, d_opcode, d_source, d_size, c_ready,
                     wr_valid, busy_addr);
         end
         tick();
      end
      d_ready = 1'b1;
      vectors++;
      if (d_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rel_fire got dv=%b want 1", d_valid);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || d_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rel_done got busy=%b dv=%b want 0 0", busy, d_valid);
      end
   endtask

   task automatic test_probe_ack();
      c_valid = 1'b1; c_opcode = 3'd4; c_param = 3'd2; c_size = 4'd6;
      c_source = 3'd4; c_address = 32'h0000_3000;
      vectors++;
      if (c_ready !== 1'b1 || probe_done !== 1'b0) begin
         miscompares++;
         $display("FAIL pa_pre got crdy=%b pd=%b want 1 0", c_ready, probe_done);
      end
      tick();
      c_valid = 1'b0;
      vectors++;
      if (probe_done !== 1'b1 || probe_param !== 3'd2 || busy !== 1'b1 ||
          d_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL pa_pulse got pd=%b pp=%0d busy=%b dv=%b want 1 2 1 0",
                  probe_done, probe_param, busy, d_valid);
      end
      tick();
      vectors++;
      if (probe_done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL pa_after got pd=%b busy=%b want 0 0", probe_done, busy);
      end
   endtask

   task automatic test_proto_err();
      wr_ready = 1'b1; d_ready = 1'b1;
      vectors++;
      if (proto_err !== 1'b0) begin
         miscompares++;
         $display("FAIL pe_pre got %b want 0", proto_err);
      end
      send_burst(3'd7, 3'd0, 3'd2, 32'h0000_4000, 64'h1234, 3, 3'd5);
      vectors++;
      if (proto_err !== 1'b1) begin
         miscompares++;
         $display("FAIL pe_set got %b want 1", proto_err);
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (wr_valid !== 1'b1 || wr_addr !== 32'h4000 + 32'(8 * i) ||
             wr_data !== 64'h1234 * 64'(i + 1)) begin
            miscompares++;
            $display("FAIL pe_write%0d got v=%b a=%h d=%h want 1 %h %h", i,
                     wr_valid, wr_addr, wr_data, 32'h4000 + 32'(8 * i),
                     64'h1234 * 64'(i + 1));
         end
         tick();
      end
      vectors++;
      if (d_valid !== 1'b1 || d_source !== 3'd2) begin
         miscompares++;
         $display("FAIL pe_ack got dv=%b src=%0d want 1 2", d_valid, d_source);
      end
      tick();
      vectors++;
      if (proto_err !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL pe_sticky got pe=%b busy=%b want 1 0", proto_err, busy);
      end
   endtask

   task automatic test_reset_mid_write();
      int acks = 0;
      wr_ready = 1'b1; d_ready = 1'b1;
      send_burst(3'd7, 3'd0, 3'd2, 32'h0000_5000, 64'h77, -1, 3'd0);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (wr_valid !== 1'b1 || wr_data !== 64'h77 * 64'(i + 1)) begin
            miscompares++;
            $display("FAIL rst_write%0d got v=%b d=%h want 1 %h", i,
                     wr_valid, wr_data, 64'h77 * 64'(i + 1));
         end
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if (busy !== 1'b0 || wr_valid !== 1'b0 || proto_err !== 1'b0 ||
          c_ready !== 1'b1 || d_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_abort got busy=%b wv=%b pe=%b crdy=%b dv=%b want 0 0 0 1 0",
                  busy, wr_valid, proto_err, c_ready, d_valid);
      end
      for (int i = 0; i < 10; i++) begin
         if (d_valid || wr_valid) acks++;
         tick();
      end
      vectors++;
      if (acks !== 0) begin
         miscompares++;
         $display("FAIL rst_quiet got %0d active cycles want 0", acks);
      end
   endtask

   task automatic test_bad_opcode();
      c_valid = 1'b1; c_opcode = 3'd2; c_param = 3'd0; c_size = 4'd6;
      c_source = 3'd1; c_address = 32'h0000_6000;
      tick();
      c_valid = 1'b0;
      vectors++;
      if (proto_err !== 1'b1 || busy !== 1'b0 || c_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_op got pe=%b busy=%b crdy=%b want 1 0 1",
                  proto_err, busy, c_ready);
      end
   endtask

   initial begin
      test_reset();
      test_release_data();
      test_probe_data();
      test_release_wait();
      test_probe_ack();
      test_proto_err();
      test_reset_mid_write();
      test_bad_opcode();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
